keypad_bcd_entry: RTL and testbench
===================================

KEYPAD_BCD_ENTRY -- requirements
Module: keypad_bcd_entry

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clk cycles per column slot (minimum 4).
REQ-002 SHALL have parameter DEBOUNCE, default 4, consecutive identical scan frames to accept a press or release (minimum 1).
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port row  input  4  keypad rows, active-low, asynchronous to clk.
REQ-006 SHALL have port col  output  4  keypad column drive, active-low one-hot.
REQ-007 SHALL have port entry  output  8  two-digit BCD entry register {tens, ones}.
REQ-008 SHALL have port a  output  8  committed BCD operand A.
REQ-009 SHALL have port b  output  8  committed BCD operand B.
REQ-010 SHALL have port key_valid  output  1  one-cycle strobe per accepted press.
REQ-011 SHALL have port key_code  output  4  code of last accepted key, held between strobes.

Function
REQ-012 SHALL synchronise row through two flops before any use.
REQ-013 SHALL rotate col 1110 -> 1101 -> 1011 -> 0111 -> 1110, advancing after SCAN_DIV cycles per slot.
REQ-014 SHALL sample synchronised row in the final cycle of each slot (slot counter == SCAN_DIV-1) into a 16-bit key map, bit = col_index*4 + row_index.
REQ-015 SHALL close a frame when the 0111 slot is sampled; frame classified as NONE (no key), ONE (exactly one key), MULTI (two or more).
REQ-016 SHALL map (row r, col c) keys: r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: E(*) 0 F(#) D.
REQ-017 SHALL implement FSM states IDLE, CONFIRM, HELD, RELEASE.
REQ-018 IDLE: frame ONE -> CONFIRM, candidate = that key, frame count = 1; NONE/MULTI stay.
REQ-019 CONFIRM: ONE same key -> count+1; count reaching DEBOUNCE -> HELD; ONE different key -> restart with new candidate, count = 1; NONE or MULTI -> IDLE.
REQ-020 On CONFIRM -> HELD transition SHALL pulse key_valid for exactly one cycle and update key_code in the same cycle.
REQ-021 HELD: NONE -> RELEASE, count = 1; ONE or MULTI stay HELD (no repeat, no new strobe).
REQ-022 RELEASE: NONE count+1, reaching DEBOUNCE -> IDLE; any key -> HELD.
REQ-023 With DEBOUNCE = 1, CONFIRM and RELEASE SHALL each be exited on the frame that entered them.
REQ-024 On strobe, digit key d (0-9): entry <= {entry[3:0], d}; the tens digit is discarded.
REQ-025 On strobe, A: a <= entry, entry <= 0; B: b <= entry, entry <= 0; C: entry, a, b <= 0; D, E, F: registers unchanged (strobe still issued).
REQ-026 entry, a, b SHALL only ever hold digits 0-9 per nibble.
REQ-027 Press latency SHALL be DEBOUNCE frames from first ONE frame, plus one clk for the strobe register.

Reset
REQ-028 rst_n low SHALL immediately force col = 1110, slot counter 0, key map 0, FSM IDLE, count 0, entry = a = b = 8'h00, key_valid = 0, key_code = 0, sync flops all ones (no key).
REQ-029 Reset asserted mid-debounce or mid-hold SHALL discard the press; after release no strobe until a fresh full debounce.

Verification (SCAN_DIV=4, DEBOUNCE=2)
REQ-030 Hold key 7 (r2,c0) for 3 frames, release -> exactly one key_valid, key_code 4'h7, entry 8'h07.
REQ-031 Press 4, 2, 9 sequentially with releases -> entry 8'h29; press A -> a = 8'h29, entry 8'h00.
REQ-032 Press 5, B, then C -> b = 8'h05 after B; entry, a, b all 8'h00 after C.
REQ-033 Hold 1 and 6 together for 4 frames -> no key_valid, entry unchanged.
REQ-034 Key 3 bounces (1 frame on, 1 off, 1 on) then held -> single strobe 4'h3 only after 2 consecutive ONE frames.
REQ-035 Assert rst_n low while key 8 in CONFIRM, keep key held through reset release -> outputs reset values, then one strobe 4'h8 after 2 full frames.

Source files
------------

// File: rtl/keypad_bcd_entry_if.sv
// Keypad-side and result signals of keypad_bcd_entry, bundled for port hookup.
// slave = the entry block itself; master = the keypad/consumer side.
interface keypad_bcd_entry_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [7:0] entry;
    logic [7:0] a;
    logic [7:0] b;
    logic       key_valid;
    logic [3:0] key_code;

    modport slave (
        input  row,
        output col, entry, a, b, key_valid, key_code
    );

    modport master (
        output row,
        input  col, entry, a, b, key_valid, key_code
    );
endinterface

// File: rtl/keypad_bcd_entry.sv
// Scans a 4x4 active-low keypad, debounces whole frames and drives a two-digit BCD entry with A/B operands.
// Latency: DEBOUNCE scan frames from the first single-key frame, plus one clk for the registered strobe.
// Backpressure: none; key_valid is a one-cycle strobe that the consumer must take when it fires.
module keypad_bcd_entry #(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    keypad_bcd_entry_if.slave kp
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] SLOT_ONE  = SW'(1);
    localparam logic [CW-1:0] DB        = CW'(DEBOUNCE);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONFIRM = 2'd1,
        HELD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    logic [3:0]    sync1_q, sync2_q;
    logic [SW-1:0] slot_q;
    logic [1:0]    col_idx_q;
    logic [15:0]   map_q, map_d;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]    cand_q, cand_d;
    logic          strobe_d;
    logic          key_valid_q;
    logic [3:0]    key_code_q;
    logic [7:0]    entry_q, a_q, b_q;

    logic          slot_end;
    logic          frame_vld;
    logic          frame_any;
    logic          frame_single;
    logic [3:0]    frame_idx;
    logic [3:0]    frame_code;

    // Key legend indexed by col*4 + row.
    function automatic logic [3:0] key_of(input logic [3:0] idx);
        logic [3:0] k;
        k = 4'h0;
        case (idx)
            4'd0:  k = 4'h1;
            4'd1:  k = 4'h4;
            4'd2:  k = 4'h7;
            4'd3:  k = 4'hE;
            4'd4:  k = 4'h2;
            4'd5:  k = 4'h5;
            4'd6:  k = 4'h8;
            4'd7:  k = 4'h0;
            4'd8:  k = 4'h3;
            4'd9:  k = 4'h6;
            4'd10: k = 4'h9;
            4'd11: k = 4'hF;
            4'd12: k = 4'hA;
            4'd13: k = 4'hB;
            4'd14: k = 4'hC;
            4'd15: k = 4'hD;
        endcase
        return k;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
        end else begin
            sync1_q <= kp.row;
            sync2_q <= sync1_q;
        end
    end

    assign slot_end  = (slot_q == SLOT_LAST);
    assign frame_vld = slot_end && (col_idx_q == 2'd3);

    // The current slot's sample is merged in live so the closing frame sees all 16 keys.
    always_comb begin
        map_d = map_q;
        map_d[{col_idx_q, 2'b00} +: 4] = ~sync2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q    <= '0;
            col_idx_q <= 2'd0;
            map_q     <= 16'h0000;
        end else if (slot_end) begin
            slot_q    <= '0;
            col_idx_q <= col_idx_q + 2'd1;
            map_q     <= map_d;
        end else begin
            slot_q    <= slot_q + SLOT_ONE;
        end
    end

    assign frame_any    = |map_d;
    assign frame_single = frame_any && ((map_d & (map_d - 16'd1)) == 16'd0);

    always_comb begin
        frame_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (map_d[i]) frame_idx = 4'(i);
        end
    end

    assign frame_code = key_of(frame_idx);
    assign cnt_inc    = cnt_q + CNT_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= 4'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
        end
    end

    // Entering CONFIRM or RELEASE already counts one frame, so DEBOUNCE=1 passes straight through.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        strobe_d = 1'b0;
        if (frame_vld) begin
            case (state_q)
                IDLE: begin
                    if (frame_single) begin
                        cand_d = frame_code;
                        if (CNT_ONE >= DB) begin
                            state_d  = HELD;
                            cnt_d    = CNT_ZERO;
                            strobe_d = 1'b1;
                        end else begin
                            state_d = CONFIRM;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                CONFIRM: begin
                    if (frame_single && (frame_code == cand_q)) begin
                        if (cnt_inc >= DB) begin
                            state_d  = HELD;
                            cnt_d    = CNT_ZERO;
                            strobe_d = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else if (frame_single) begin
                        cand_d = frame_code;
                        if (CNT_ONE >= DB) begin
                            state_d  = HELD;
                            cnt_d    = CNT_ZERO;
                            strobe_d = 1'b1;
                        end else begin
                            cnt_d = CNT_ONE;
                        end
                    end else begin
                        state_d = IDLE;
                        cnt_d   = CNT_ZERO;
                    end
                end
                HELD: begin
                    if (!frame_any) begin
                        if (CNT_ONE >= DB) begin
                            state_d = IDLE;
                            cnt_d   = CNT_ZERO;
                        end else begin
                            state_d = RELEASE;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                RELEASE: begin
                    if (frame_any) begin
                        state_d = HELD;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_inc >= DB) begin
                        state_d = IDLE;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // Every key code stored in a nibble is 0-9, so entry/a/b stay valid BCD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            entry_q     <= 8'h00;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
        end else begin
            key_valid_q <= strobe_d;
            if (strobe_d) begin
                key_code_q <= frame_code;
                if (frame_code < 4'd10) begin
                    entry_q <= {entry_q[3:0], frame_code};
                end else begin
                    case (frame_code)
                        4'hA: begin
                            a_q     <= entry_q;
                            entry_q <= 8'h00;
                        end
                        4'hB: begin
                            b_q     <= entry_q;
                            entry_q <= 8'h00;
                        end
                        4'hC: begin
                            a_q     <= 8'h00;
                            b_q     <= 8'h00;
                            entry_q <= 8'h00;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign kp.col       = ~(4'b0001 << col_idx_q);
    assign kp.entry     = entry_q;
    assign kp.a         = a_q;
    assign kp.b         = b_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_code  = key_code_q;

endmodule

// File: tb/tb_keypad_bcd_entry.sv
// Frame-aligned keypad stimulus: directed table, randomized frames against a sliding-window model, reset mid-debounce.
module tb_keypad_bcd_entry;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 2;
    localparam int FRAME    = 4 * SCAN_DIV;

    localparam logic [3:0] KEY_AT [16] = '{4'h1, 4'h4, 4'h7, 4'hE, 4'h2, 4'h5, 4'h8, 4'h0,
                                           4'h3, 4'h6, 4'h9, 4'hF, 4'hA, 4'hB, 4'hC, 4'hD};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] press_mask = 16'h0000;
    logic [3:0]  row_drv;

    int n_vec = 0;
    int n_err = 0;

    keypad_bcd_entry_if kif();

    keypad_bcd_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kif)
    );

    always #5 clk = ~clk;

    // A pressed key shorts its row low while its column is driven low.
    always_comb begin
        row_drv = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!kif.col[c] && press_mask[c*4+r]) row_drv[r] = 1'b0;
    end
    assign kif.row = row_drv;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] kmask(input logic [3:0] code);
        logic [15:0] m;
        m = 16'h0000;
        for (int i = 0; i < 16; i++)
            if (KEY_AT[i] == code) m[i] = 1'b1;
        return m;
    endfunction

    // ---------------- reference model: decimal registers + window of frame classes
    int         hist[$];
    bit         m_held;
    int         m_entry, m_a, m_b;
    logic [3:0] m_code;

    function automatic logic [7:0] bcd(input int x);
        return {4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic int classify(input logic [15:0] m);
        int n, k;
        n = 0;
        k = -1;
        for (int i = 0; i < 16; i++)
            if (m[i]) begin
                n++;
                k = int'(KEY_AT[i]);
            end
        if (n == 0) return -1;
        if (n > 1) return -2;
        return k;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_held  = 0;
        m_entry = 0;
        m_a     = 0;
        m_b     = 0;
        m_code  = 4'h0;
    endtask

    task automatic model_apply(input int k);
        m_code = 4'(k);
        if (k <= 9) m_entry = (m_entry % 10) * 10 + k;
        else if (k == 10) begin m_a = m_entry; m_entry = 0; end
        else if (k == 11) begin m_b = m_entry; m_entry = 0; end
        else if (k == 12) begin m_a = 0; m_b = 0; m_entry = 0; end
    endtask

    // A press is accepted when the last DEBOUNCE frames show the same single key;
    // it is released once the last DEBOUNCE frames are all empty.
    task automatic model_frame(input logic [15:0] m, output bit strobe);
        bit same;
        strobe = 0;
        hist.push_back(classify(m));
        if (hist.size() > DEBOUNCE) void'(hist.pop_front());
        if (hist.size() == DEBOUNCE) begin
            same = 1;
            foreach (hist[i]) if (hist[i] != hist[0]) same = 0;
            if (!m_held && same && hist[0] >= 0) begin
                strobe = 1;
                m_held = 1;
                model_apply(hist[0]);
            end else if (m_held && same && hist[0] == -1) begin
                m_held = 0;
            end
        end
    endtask

    // ---------------- one full scan frame with the given keys held
    task automatic do_frame(input logic [15:0] m, output int ns, output logic [3:0] sc);
        bit colbad;
        colbad = 0;
        ns = 0;
        sc = 4'h0;
        press_mask = m;
        for (int j = 1; j <= FRAME; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (kif.key_valid) begin
                ns++;
                sc = kif.key_code;
            end
            if (kif.col !== ~(4'b0001 << ((j / SCAN_DIV) % 4))) colbad = 1;
        end
        chk("col_rotation", 16'(colbad), 16'd0);
    endtask

    task automatic frame_vs_model(input logic [15:0] m);
        int         ns;
        logic [3:0] sc;
        bit         s;
        do_frame(m, ns, sc);
        model_frame(m, s);
        chk("strobe_count", 16'(ns), 16'(s));
        if (s) chk("strobe_code", 16'(sc), 16'(m_code));
        chk("key_code", 16'(kif.key_code), 16'(m_code));
        chk("entry", 16'(kif.entry), 16'(bcd(m_entry)));
        chk("a", 16'(kif.a), 16'(bcd(m_a)));
        chk("b", 16'(kif.b), 16'(bcd(m_b)));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_col"}, 16'(kif.col), 16'h000E);
        chk({tag, "_key_valid"}, 16'(kif.key_valid), 16'd0);
        chk({tag, "_key_code"}, 16'(kif.key_code), 16'd0);
        chk({tag, "_entry"}, 16'(kif.entry), 16'd0);
        chk({tag, "_a"}, 16'(kif.a), 16'd0);
        chk({tag, "_b"}, 16'(kif.b), 16'd0);
    endtask

    typedef struct {
        logic [15:0] mask;
        int          vld;
        logic [3:0]  code;
        logic [7:0]  entry;
        logic [7:0]  a;
        logic [7:0]  b;
    } vec_t;

    function automatic vec_t mk(input logic [15:0] mask, input int vld, input logic [3:0] code,
                                input logic [7:0] entry, input logic [7:0] a, input logic [7:0] b);
        vec_t v;
        v.mask = mask; v.vld = vld; v.code = code; v.entry = entry; v.a = a; v.b = b;
        return v;
    endfunction

    initial begin
        vec_t       vecs[$];
        int         ns;
        logic [3:0] sc;
        bit         s;
        logic [15:0] N, K1, K2, K3, K4, K5, K6, K7, K8, K9, KA, KB, KC;

        N  = 16'h0000;
        K1 = kmask(4'h1); K2 = kmask(4'h2); K3 = kmask(4'h3); K4 = kmask(4'h4);
        K5 = kmask(4'h5); K6 = kmask(4'h6); K7 = kmask(4'h7); K8 = kmask(4'h8);
        K9 = kmask(4'h9); KA = kmask(4'hA); KB = kmask(4'hB); KC = kmask(4'hC);

        // Hold 7 for three frames, then release
        vecs.push_back(mk(K7, 0, 4'h0, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(K7, 1, 4'h7, 8'h07, 8'h00, 8'h00));
        vecs.push_back(mk(K7, 0, 4'h7, 8'h07, 8'h00, 8'h00));
        vecs.push_back(mk(N,  0, 4'h7, 8'h07, 8'h00, 8'h00));
        vecs.push_back(mk(N,  0, 4'h7, 8'h07, 8'h00, 8'h00));
        // 4, 2, 9, then A
        vecs.push_back(mk(K4, 0, 4'h7, 8'h07, 8'h00, 8'h00));
        vecs.push_back(mk(K4, 1, 4'h4, 8'h74, 8'h00, 8'h00));
        vecs.push_back(mk(N,  0, 4'h4, 8'h74, 8'h00, 8'h00));
        vecs.push_back(mk(N,  0, 4'h4, 8'h74, 8'h00, 8'h00));
        vecs.push_back(mk(K2, 0, 4'h4, 8'h74, 8'h00, 8'h00));
        vecs.push_back(mk(K2, 1, 4'h2, 8'h42, 8'h00, 8'h00));
        vecs.push_back(mk(N,  0, 4'h2, 8'h42, 8'h00, 8'h00));
        vecs.push_back(mk(N,  0, 4'h2, 8'h42, 8'h00, 8'h00));
        vecs.push_back(mk(K9, 0, 4'h2, 8'h42, 8'h00, 8'h00));
        vecs.push_back(mk(K9, 1, 4'h9, 8'h29, 8'h00, 8'h00));
        vecs.push_back(mk(N,  0, 4'h9, 8'h29, 8'h00, 8'h00));
        vecs.push_back(mk(N,  0, 4'h9, 8'h29, 8'h00, 8'h00));
        vecs.push_back(mk(KA, 0, 4'h9, 8'h29, 8'h00, 8'h00));
        vecs.push_back(mk(KA, 1, 4'hA, 8'h00, 8'h29, 8'h00));
        vecs.push_back(mk(N,  0, 4'hA, 8'h00, 8'h29, 8'h00));
        vecs.push_back(mk(N,  0, 4'hA, 8'h00, 8'h29, 8'h00));
        // 5, B, C
        vecs.push_back(mk(K5, 0, 4'hA, 8'h00, 8'h29, 8'h00));
        vecs.push_back(mk(K5, 1, 4'h5, 8'h05, 8'h29, 8'h00));
        vecs.push_back(mk(N,  0, 4'h5, 8'h05, 8'h29, 8'h00));
        vecs.push_back(mk(N,  0, 4'h5, 8'h05, 8'h29, 8'h00));
        vecs.push_back(mk(KB, 0, 4'h5, 8'h05, 8'h29, 8'h00));
        vecs.push_back(mk(KB, 1, 4'hB, 8'h00, 8'h29, 8'h05));
        vecs.push_back(mk(N,  0, 4'hB, 8'h00, 8'h29, 8'h05));
        vecs.push_back(mk(N,  0, 4'hB, 8'h00, 8'h29, 8'h05));
        vecs.push_back(mk(KC, 0, 4'hB, 8'h00, 8'h29, 8'h05));
        vecs.push_back(mk(KC, 1, 4'hC, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(N,  0, 4'hC, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(N,  0, 4'hC, 8'h00, 8'h00, 8'h00));
        // 1 and 6 together: never accepted
        for (int i = 0; i < 4; i++) vecs.push_back(mk(K1 | K6, 0, 4'hC, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(N,  0, 4'hC, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(N,  0, 4'hC, 8'h00, 8'h00, 8'h00));
        // 3 bounces on/off/on, then held
        vecs.push_back(mk(K3, 0, 4'hC, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(N,  0, 4'hC, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(K3, 0, 4'hC, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(K3, 1, 4'h3, 8'h03, 8'h00, 8'h00));
        vecs.push_back(mk(K3, 0, 4'h3, 8'h03, 8'h00, 8'h00));
        vecs.push_back(mk(N,  0, 4'h3, 8'h03, 8'h00, 8'h00));
        vecs.push_back(mk(N,  0, 4'h3, 8'h03, 8'h00, 8'h00));

        // ---- reset state
        rst_n = 1'b0;
        press_mask = N;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        model_reset();

        // ---- directed table
        for (int i = 0; i < vecs.size(); i++) begin
            do_frame(vecs[i].mask, ns, sc);
            model_frame(vecs[i].mask, s);
            chk($sformatf("vec%0d_strobes", i), 16'(ns), 16'(vecs[i].vld));
            if (vecs[i].vld != 0) chk($sformatf("vec%0d_strobe_code", i), 16'(sc), 16'(vecs[i].code));
            chk($sformatf("vec%0d_key_code", i), 16'(kif.key_code), 16'(vecs[i].code));
            chk($sformatf("vec%0d_entry", i), 16'(kif.entry), 16'(vecs[i].entry));
            chk($sformatf("vec%0d_a", i), 16'(kif.a), 16'(vecs[i].a));
            chk($sformatf("vec%0d_b", i), 16'(kif.b), 16'(vecs[i].b));
        end

        // ---- randomized frames against the model
        for (int it = 0; it < 40; it++) begin
            logic [15:0] m;
            int sel, hold, i0, i1;
            sel  = int'($urandom_range(0, 9));
            hold = int'($urandom_range(1, 4));
            m    = 16'h0000;
            if (sel >= 4 && sel < 9) begin
                i0 = int'($urandom_range(0, 15));
                m[i0] = 1'b1;
            end else if (sel == 9) begin
                i0 = int'($urandom_range(0, 15));
                i1 = (i0 + int'($urandom_range(1, 15))) % 16;
                m[i0] = 1'b1;
                m[i1] = 1'b1;
            end
            for (int h = 0; h < hold; h++) frame_vs_model(m);
        end

        // ---- reset while 8 is in its debounce window, key kept held
        frame_vs_model(N);
        frame_vs_model(N);
        frame_vs_model(K8);
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async_reset");
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("held_reset");
        rst_n = 1'b1;
        model_reset();
        do_frame(K8, ns, sc);
        model_frame(K8, s);
        chk("post_reset_frame1_strobes", 16'(ns), 16'd0);
        do_frame(K8, ns, sc);
        model_frame(K8, s);
        chk("post_reset_frame2_strobes", 16'(ns), 16'd1);
        chk("post_reset_strobe_code", 16'(sc), 16'h0008);
        chk("post_reset_entry", 16'(kif.entry), 16'h0008);
        frame_vs_model(N);
        frame_vs_model(N);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
